// File: rtl/cynapse_route_pkg.sv
// Shared definitions for the spike routing path.
//   route_state_e        : controller FSM states of spike_route_scheduler
//   NEURON_WIDTH_DEFAULT : default width of a neuron ID
package cynapse_route_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for a routing phase
        ST_PRESENT = 2'd1,  // NeuronID set up, RouteEnable still low
        ST_ROUTE   = 2'd2,  // RouteEnable high until RoutingComplete
        ST_GAP     = 2'd3   // one low cycle so InputRouter can clear its state
    } route_state_e;

    localparam int NEURON_WIDTH_DEFAULT = 11;

endpackage

// File: rtl/spike_route_scheduler_fifo.sv
// spike_fifo: circular queue of spiked neuron IDs.
// Optional feature macro: SPIKE_DROP_COUNT_EN (adds a saturating drop counter).
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync clear)
//   push_valid_i / push_data_i : push request; accepted when not full or popping
//   pop_i                      : remove head (ignored when empty)
//   head_data_o                : current head entry
//   empty_o, full_o, count_o   : occupancy status
//   overflow_o                 : sticky, a push was dropped
//   dropped_o                  : saturating drop count (SPIKE_DROP_COUNT_EN only)
module spike_fifo #(
    parameter int DATA_WIDTH       = 11,
    parameter int DEPTH_LOG2       = 6
`ifdef SPIKE_DROP_COUNT_EN
    ,
    parameter int DROP_COUNT_WIDTH = 16
`endif
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic                        push_valid_i,
    input  logic [DATA_WIDTH-1:0]       push_data_i,
    input  logic                        pop_i,
    output logic [DATA_WIDTH-1:0]       head_data_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [DEPTH_LOG2:0]         count_o,
`ifdef SPIKE_DROP_COUNT_EN
    output logic [DROP_COUNT_WIDTH-1:0] dropped_o,
`endif
    output logic                        overflow_o
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q;
    logic [DEPTH_LOG2-1:0] tail_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  drop;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == DEPTH_C);
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign head_data_o = mem_q[head_q];

    assign pop_ok  = pop_i & ~empty_o;
    // A pop on the same edge frees the slot, so a full queue still accepts.
    assign push_ok = push_valid_i & (~full_o | pop_ok);
    assign drop    = push_valid_i & full_o & ~pop_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers are exactly DEPTH_LOG2 bits, so increments wrap modulo depth.
            if (push_ok) tail_q <= tail_q + 1'b1;
            if (pop_ok)  head_q <= head_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

`ifdef SPIKE_DROP_COUNT_EN
    logic [DROP_COUNT_WIDTH-1:0] dropped_q;
    assign dropped_o = dropped_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dropped_q <= '0;
        end else if (clear_i) begin
            dropped_q <= '0;
        end else if (drop && (dropped_q != '1)) begin
            dropped_q <= dropped_q + 1'b1;
        end
    end
`endif

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/spike_route_scheduler.sv
// spike_route_scheduler: queues IDs of neurons that spiked during the update
// phase and presents them one at a time to InputRouter during the routing phase.
// Optional feature macro: SPIKE_DROP_COUNT_EN (adds DroppedSpikes port/counter).
// Ports:
//   Clock, Reset (async, active-high), Initialize (sync clear)
//   SpikeValid / SpikeID         : push from the neuron update unit
//   RouteStart                   : 1-cycle pulse starting the routing phase
//   RoutingComplete              : InputRouter finished the current NeuronID
//   RouteEnable / NeuronID       : registered outputs to InputRouter
//   RoutePhaseDone               : 1-cycle pulse, queue drained
//   QueueEmpty/QueueFull/QueueCount, Overflow, DroppedSpikes : status
//   DebugState                   : current controller FSM state
// Handshake: NeuronID is loaded one cycle before RouteEnable rises and is held
// while RouteEnable=1; RouteEnable stays high until RoutingComplete is sampled
// high, then drops for at least one cycle before the next ID is presented.
module spike_route_scheduler
    import cynapse_route_pkg::*;
#(
    parameter int NEURON_WIDTH     = NEURON_WIDTH_DEFAULT,
    parameter int QUEUE_DEPTH_LOG2 = 6
`ifdef SPIKE_DROP_COUNT_EN
    ,
    parameter int DROP_COUNT_WIDTH = 16
`endif
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Initialize,
    input  logic                        SpikeValid,
    input  logic [NEURON_WIDTH-1:0]     SpikeID,
    input  logic                        RouteStart,
    input  logic                        RoutingComplete,
    output logic                        RouteEnable,
    output logic [NEURON_WIDTH-1:0]     NeuronID,
    output logic                        RoutePhaseDone,
    output logic                        QueueEmpty,
    output logic                        QueueFull,
    output logic [QUEUE_DEPTH_LOG2:0]   QueueCount,
    output logic                        Overflow,
`ifdef SPIKE_DROP_COUNT_EN
    output logic [DROP_COUNT_WIDTH-1:0] DroppedSpikes,
`endif
    output logic [1:0]                  DebugState
);

    route_state_e              state_q;
    logic                      route_en_q;
    logic [NEURON_WIDTH-1:0]   neuron_id_q;
    logic                      done_q;
    logic                      route_active_q;
    logic                      go;
    logic                      pop;
    logic                      fifo_empty;
    logic [NEURON_WIDTH-1:0]   head_data;

    spike_fifo #(
        .DATA_WIDTH       (NEURON_WIDTH),
        .DEPTH_LOG2       (QUEUE_DEPTH_LOG2)
`ifdef SPIKE_DROP_COUNT_EN
        ,
        .DROP_COUNT_WIDTH (DROP_COUNT_WIDTH)
`endif
    ) u_fifo (
        .clk_i        (Clock),
        .rst_i        (Reset),
        .clear_i      (Initialize),
        .push_valid_i (SpikeValid),
        .push_data_i  (SpikeID),
        .pop_i        (pop),
        .head_data_o  (head_data),
        .empty_o      (fifo_empty),
        .full_o       (QueueFull),
        .count_o      (QueueCount),
`ifdef SPIKE_DROP_COUNT_EN
        .dropped_o    (DroppedSpikes),
`endif
        .overflow_o   (Overflow)
    );

    assign go = RouteStart | route_active_q;

    // Pop exactly on the transitions into PRESENT.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            ST_IDLE: pop = go & ~fifo_empty;
            ST_GAP:  pop = ~fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            route_en_q     <= 1'b0;
            neuron_id_q    <= '0;
            done_q         <= 1'b0;
            route_active_q <= 1'b0;
        end else if (Initialize) begin
            state_q        <= ST_IDLE;
            route_en_q     <= 1'b0;
            neuron_id_q    <= '0;
            done_q         <= 1'b0;
            route_active_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (RouteStart) route_active_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        if (!fifo_empty) begin
                            state_q     <= ST_PRESENT;
                            neuron_id_q <= head_data;
                        end else begin
                            // Nothing to route: end the phase straight away.
                            done_q         <= 1'b1;
                            route_active_q <= 1'b0;
                        end
                    end
                end
                ST_PRESENT: begin
                    state_q    <= ST_ROUTE;
                    route_en_q <= 1'b1;
                end
                ST_ROUTE: begin
                    if (RoutingComplete) begin
                        state_q    <= ST_GAP;
                        route_en_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    // Spikes pushed mid-phase are still drained in this phase.
                    if (!fifo_empty) begin
                        state_q     <= ST_PRESENT;
                        neuron_id_q <= head_data;
                    end else begin
                        state_q        <= ST_IDLE;
                        done_q         <= 1'b1;
                        route_active_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign RouteEnable    = route_en_q;
    assign NeuronID       = neuron_id_q;
    assign RoutePhaseDone = done_q;
    assign QueueEmpty     = fifo_empty;
    assign DebugState     = state_q;

endmodule

// File: tb/tb_spike_route_scheduler.sv
module tb_spike_route_scheduler;
  import cynapse_route_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        init_s = 1'b0;
  logic        spike_valid = 1'b0;
  logic [10:0] spike_id = '0;
  logic        route_start = 1'b0;
  logic        routing_complete = 1'b0;
  logic        route_enable;
  logic [10:0] neuron_id;
  logic        phase_done;
  logic        q_empty;
  logic        q_full;
  logic [6:0]  q_count;
  logic        overflow;
  logic [1:0]  dbg_state;
`ifdef SPIKE_DROP_COUNT_EN
  logic [15:0] dropped;
`endif

  spike_route_scheduler dut (
    .Clock           (clk),
    .Reset           (rst),
    .Initialize      (init_s),
    .SpikeValid      (spike_valid),
    .SpikeID         (spike_id),
    .RouteStart      (route_start),
    .RoutingComplete (routing_complete),
    .RouteEnable     (route_enable),
    .NeuronID        (neuron_id),
    .RoutePhaseDone  (phase_done),
    .QueueEmpty      (q_empty),
    .QueueFull       (q_full),
    .QueueCount      (q_count),
    .Overflow        (overflow),
`ifdef SPIKE_DROP_COUNT_EN
    .DroppedSpikes   (dropped),
`endif
    .DebugState      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init_s = 1'b1;
    step();
    init_s = 1'b0;
  endtask

  task automatic push(input logic [10:0] id);
    spike_valid = 1'b1;
    spike_id = id;
    step();
    spike_valid = 1'b0;
  endtask

  // Acts as InputRouter: records each ID on a RouteEnable rise, returns
  // RoutingComplete rc_delay edges after the rise, optionally pushes inj_id
  // on cycle inj_cycle. Stops at the first RoutePhaseDone or budget expiry.
  task automatic run_router(input int rc_delay, input int inj_cycle,
                            input logic [10:0] inj_id, input int budget,
                            output int done_cnt, output int routed_at_done);
    int timer;
    logic prev_re;
    logic [10:0] held;
    bit finished;
    timer = 0;
    prev_re = route_enable;
    held = '0;
    finished = 0;
    done_cnt = 0;
    routed_at_done = -1;
    for (int c = 0; c < budget && !finished; c++) begin
      route_start = (c == 0);
      routing_complete = (timer == 1);
      spike_valid = (c == inj_cycle);
      spike_id = inj_id;
      step();
      route_start = 1'b0;
      routing_complete = 1'b0;
      spike_valid = 1'b0;
      if (timer > 0) timer--;
      if (route_enable && !prev_re) begin
        got_q.push_back(neuron_id);
        held = neuron_id;
        timer = rc_delay;
      end else if (route_enable) begin
        chk("neuron_id_stable", {21'd0, neuron_id}, {21'd0, held});
      end
      if (phase_done) begin
        done_cnt++;
        routed_at_done = got_q.size();
        chk("re_low_at_done", {31'd0, route_enable}, 32'd0);
        chk("empty_at_done", {31'd0, q_empty}, 32'd1);
        finished = 1;
      end
      prev_re = route_enable;
    end
    if (!finished) chk("router_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sv;
    logic [10:0] sid;
    logic        rs;
    logic        rc;
    logic        e_re;
    logic [10:0] e_nid;
    logic        e_done;
    logic [6:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic sv, input logic [10:0] sid, input logic rs,
                              input logic rc, input logic e_re, input logic [10:0] e_nid,
                              input logic e_done, input logic [6:0] e_cnt);
    vec_t v;
    v.sv = sv; v.sid = sid; v.rs = rs; v.rc = rc;
    v.e_re = e_re; v.e_nid = e_nid; v.e_done = e_done; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  int dcnt;
  int routed;

  initial begin
    // Test 1: push 5,17,900; route with RoutingComplete 4 edges after each rise.
    add(1, 11'd5,   0, 0, 0, 11'd0,   0, 7'd1);
    add(1, 11'd17,  0, 0, 0, 11'd0,   0, 7'd2);
    add(1, 11'd900, 0, 0, 0, 11'd0,   0, 7'd3);
    add(0, 11'd0,   1, 0, 0, 11'd5,   0, 7'd2);  // pop 5 into NeuronID
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 11'd5, 0, 7'd2);
    add(0, 11'd0,   0, 1, 0, 11'd5,   0, 7'd2);  // RoutingComplete -> GAP
    add(0, 11'd0,   0, 0, 0, 11'd17,  0, 7'd1);  // GAP -> PRESENT
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 11'd17, 0, 7'd1);
    add(0, 11'd0,   0, 1, 0, 11'd17,  0, 7'd1);
    add(0, 11'd0,   0, 0, 0, 11'd900, 0, 7'd0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 11'd900, 0, 7'd0);
    add(0, 11'd0,   0, 1, 0, 11'd900, 0, 7'd0);
    add(0, 11'd0,   0, 0, 0, 11'd900, 1, 7'd0);  // GAP empty -> done
    add(0, 11'd0,   0, 0, 0, 11'd900, 0, 7'd0);
    // Test 2: RouteStart on empty queue -> done next cycle, no RouteEnable.
    add(0, 11'd0,   1, 0, 0, 11'd900, 1, 7'd0);
    add(0, 11'd0,   0, 0, 0, 11'd900, 0, 7'd0);
    // RoutingComplete outside ROUTE is ignored.
    add(0, 11'd0,   0, 1, 0, 11'd900, 0, 7'd0);

    // Reset state
    #12;
    chk("rst_re", {31'd0, route_enable}, 32'd0);
    chk("rst_nid", {21'd0, neuron_id}, 32'd0);
    chk("rst_done", {31'd0, phase_done}, 32'd0);
    chk("rst_empty", {31'd0, q_empty}, 32'd1);
    chk("rst_full", {31'd0, q_full}, 32'd0);
    chk("rst_count", {25'd0, q_count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      spike_valid = vecs[i].sv;
      spike_id = vecs[i].sid;
      route_start = vecs[i].rs;
      routing_complete = vecs[i].rc;
      step();
      spike_valid = 1'b0;
      route_start = 1'b0;
      routing_complete = 1'b0;
      chk($sformatf("vec%0d_re", i), {31'd0, route_enable}, {31'd0, vecs[i].e_re});
      chk($sformatf("vec%0d_nid", i), {21'd0, neuron_id}, {21'd0, vecs[i].e_nid});
      chk($sformatf("vec%0d_done", i), {31'd0, phase_done}, {31'd0, vecs[i].e_done});
      chk($sformatf("vec%0d_count", i), {25'd0, q_count}, {25'd0, vecs[i].e_cnt});
      chk($sformatf("vec%0d_empty", i), {31'd0, q_empty}, {31'd0, (vecs[i].e_cnt == 7'd0)});
    end

    // Test 4: full queue, push on the GAP->PRESENT pop edge.
    do_init();
    for (int i = 0; i < 64; i++) push(11'(100 + i));
    chk("t4_full", {31'd0, q_full}, 32'd1);
    chk("t4_count64", {25'd0, q_count}, 32'd64);
    chk("t4_no_overflow", {31'd0, overflow}, 32'd0);
    route_start = 1'b1;
    step();
    route_start = 1'b0;
    chk("t4_first_id", {21'd0, neuron_id}, 32'd100);
    chk("t4_count63", {25'd0, q_count}, 32'd63);
    push(11'd200);                      // refill during PRESENT->ROUTE
    chk("t4_re_up", {31'd0, route_enable}, 32'd1);
    chk("t4_refull", {31'd0, q_full}, 32'd1);
    routing_complete = 1'b1;
    step();
    routing_complete = 1'b0;
    chk("t4_gap_re", {31'd0, route_enable}, 32'd0);
    push(11'd3);                        // same edge as GAP->PRESENT pop
    chk("t4_pushpop_count", {25'd0, q_count}, 32'd64);
    chk("t4_pushpop_overflow", {31'd0, overflow}, 32'd0);
    chk("t4_second_id", {21'd0, neuron_id}, 32'd101);
    step();
    chk("t4_route_again", {31'd0, route_enable}, 32'd1);
    // Initialize mid-ROUTE aborts routing.
    do_init();
    chk("init_re", {31'd0, route_enable}, 32'd0);
    chk("init_nid", {21'd0, neuron_id}, 32'd0);
    chk("init_count", {25'd0, q_count}, 32'd0);
    chk("init_empty", {31'd0, q_empty}, 32'd1);

    // Test 3: 65 pushes into depth 64, no pop.
    for (int i = 0; i < 65; i++) begin
      push(11'(i));
      if (i == 63) chk("t3_no_overflow_at_64", {31'd0, overflow}, 32'd0);
    end
    chk("t3_full", {31'd0, q_full}, 32'd1);
    chk("t3_count", {25'd0, q_count}, 32'd64);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
`ifdef SPIKE_DROP_COUNT_EN
    chk("t3_dropped", {16'd0, dropped}, 32'd1);
`endif
    step();
    chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Test 5: asynchronous Reset mid-ROUTE.
    do_init();
    chk("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
    push(11'd9);
    push(11'd10);
    route_start = 1'b1;
    step();
    route_start = 1'b0;
    step();
    chk("t5_in_route", {31'd0, route_enable}, 32'd1);
    chk("t5_nid9", {21'd0, neuron_id}, 32'd9);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_re", {31'd0, route_enable}, 32'd0);
    chk("t5_async_nid", {21'd0, neuron_id}, 32'd0);
    step();
    #3;
    rst = 1'b0;
    step();
    chk("t5_count_after", {25'd0, q_count}, 32'd0);
    chk("t5_empty_after", {31'd0, q_empty}, 32'd1);

    // Test 6: push during routing is routed in the same phase.
    push(11'd7);
    push(11'd8);
    exp_q = '{11'd7, 11'd8, 11'd42};
    got_q.delete();
    run_router(4, 3, 11'd42, 200, dcnt, routed);
    chk("t6_done_once", dcnt, 32'd1);
    chk("t6_routed_before_done", routed, 32'd3);
    chk("t6_routed_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size())
        chk($sformatf("t6_id%0d", i), {21'd0, got_q[i]}, {21'd0, exp_q[i]});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_extra_done", {31'd0, phase_done}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
